periph_bus_fifo: RTL and testbench

PERIPH_BUS_FIFO -- requirements
Module: periph_bus_fifo

---
 rtl/periph_bus_fifo_pkg.sv | 29 ++
 rtl/periph_bus_fifo_if.sv | 12 +
 rtl/periph_bus_fifo_fifo.sv | 53 +++++
 rtl/periph_bus_fifo.sv | 177 +++++++++++++++++
 tb/tb_periph_bus_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_bus_fifo_pkg.sv
// Shared constants for the peripheral bus block: register map,
// UART_CON bit positions and the TX sequencer state encoding.
package periph_pkg;

  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI     = 32'h4000_0014;
  localparam logic [31:0] ADDR_UART_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_UART_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

  localparam int unsigned UCON_RX_IRQ_EN   = 0;
  localparam int unsigned UCON_TX_FULL     = 1;
  localparam int unsigned UCON_RX_NONEMPTY = 2;
  localparam int unsigned UCON_TX_EMPTY    = 3;
  localparam int unsigned UCON_RX_OVF      = 4;
  localparam int unsigned UCON_TX_OVF      = 5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_BUSY,
    TX_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/periph_bus_fifo_if.sv
// Processor-side bus: read/write strobes, byte address, write data and
// combinational read data.
interface periph_bus_fifo_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/periph_bus_fifo_fifo.sv
// byte_fifo: power-of-two deep byte FIFO. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/periph_bus_fifo.sv
// periph_bus_fifo: memory-mapped timer, LED/switch/7-seg registers and a
// FIFO-buffered UART. Define PERIPH_UART_IRQ_EN to add the UART receive
// interrupt (UART_CON[0] enable) to irqout.
module periph_bus_fifo
  import periph_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned SW_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  periph_bus_fifo_if.slave     bus,
  output logic [LED_W-1:0]     led,
  input  logic [SW_W-1:0]      switch,
  output logic [11:0]          digi,
  output logic                 irqout,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      r_th;
  logic [31:0]      r_tl;
  logic [2:0]       r_tcon;
  logic [LED_W-1:0] r_led;
  logic [11:0]      r_digi;
  logic             r_rx_ovf;
  logic             r_tx_ovf;
  tx_state_e        r_tx_state;
  logic             r_tx_start;
  logic [7:0]       r_tx_data;

  logic w_wr_th, w_wr_tl, w_wr_tcon, w_wr_led, w_wr_digi, w_wr_txd, w_wr_ucon;
  logic w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf_evt;
  logic w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovf_evt;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic [7:0]    w_tx_head, w_rx_head;
  logic          w_rx_irq_en;
  logic [31:0]   w_ucon;

  assign w_wr_th   = bus.wr && (bus.addr == ADDR_TH);
  assign w_wr_tl   = bus.wr && (bus.addr == ADDR_TL);
  assign w_wr_tcon = bus.wr && (bus.addr == ADDR_TCON);
  assign w_wr_led  = bus.wr && (bus.addr == ADDR_LED);
  assign w_wr_digi = bus.wr && (bus.addr == ADDR_DIGI);
  assign w_wr_txd  = bus.wr && (bus.addr == ADDR_UART_TXD);
  assign w_wr_ucon = bus.wr && (bus.addr == ADDR_UART_CON);
  assign w_rx_pop  = bus.rd && (bus.addr == ADDR_UART_RXD);
  assign w_tx_pop  = (r_tx_state == TX_SEND);

  // A push into a full FIFO only overflows when no pop frees a slot.
  assign w_tx_ovf_evt = w_wr_txd & w_tx_full & ~w_tx_pop;
  assign w_rx_ovf_evt = rx_valid & w_rx_full & ~w_rx_pop;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(w_wr_txd), .pop(w_tx_pop),
    .din(bus.wdata[7:0]), .full(w_tx_full), .empty(w_tx_empty),
    .count(w_tx_count), .head(w_tx_head)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_valid), .pop(w_rx_pop),
    .din(rx_data), .full(w_rx_full), .empty(w_rx_empty),
    .count(w_rx_count), .head(w_rx_head)
  );

  // Timer: free-running TL with reload from TH; bus writes win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      if (w_wr_th) r_th <= bus.wdata;
      if (w_wr_tl) r_tl <= bus.wdata;
      else if (r_tcon[0]) r_tl <= (r_tl == '1) ? r_th : r_tl + 32'd1;
      if (w_wr_tcon) r_tcon <= bus.wdata[2:0];
      else if (r_tcon[0] && r_tcon[1] && (r_tl == '1) && !w_wr_tl) r_tcon[2] <= 1'b1;
    end
  end

  // LED and 7-segment output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else begin
      if (w_wr_led)  r_led  <= bus.wdata[LED_W-1:0];
      if (w_wr_digi) r_digi <= bus.wdata[11:0];
    end
  end

  // Sticky overflow flags; a new overflow beats a same-cycle W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_rx_ovf_evt) r_rx_ovf <= 1'b1;
      else if (w_wr_ucon && bus.wdata[UCON_RX_OVF]) r_rx_ovf <= 1'b0;
      if (w_tx_ovf_evt) r_tx_ovf <= 1'b1;
      else if (w_wr_ucon && bus.wdata[UCON_TX_OVF]) r_tx_ovf <= 1'b0;
    end
  end

`ifdef PERIPH_UART_IRQ_EN
  logic r_rx_irq_en;

  // Receive interrupt enable, written through UART_CON[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_rx_irq_en <= 1'b0;
    else if (w_wr_ucon) r_rx_irq_en <= bus.wdata[UCON_RX_IRQ_EN];
  end

  assign w_rx_irq_en = r_rx_irq_en;
  assign irqout      = r_tcon[2] | (r_rx_irq_en & ~w_rx_empty);
`else
  assign w_rx_irq_en = 1'b0;
  assign irqout      = r_tcon[2];
`endif

  // TX sequencer: one-cycle start strobe, data held until the line is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if ((w_tx_count != '0) && !tx_busy) begin
            r_tx_state <= TX_SEND;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_tx_head;
          end
        end
        TX_SEND: begin
          r_tx_start <= 1'b0;
          r_tx_state <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: if (tx_busy)  r_tx_state <= TX_WAIT_DONE;
        TX_WAIT_DONE: if (!tx_busy) r_tx_state <= TX_IDLE;
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign led      = r_led;
  assign digi     = r_digi;

  assign w_ucon = {16'b0, 8'(w_rx_count), 2'b00, r_tx_ovf, r_rx_ovf,
                   w_tx_empty, ~w_rx_empty, w_tx_full, w_rx_irq_en};

  // Combinational read mux; zero when idle or unmapped.
  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      case (bus.addr)
        ADDR_TH:       bus.rdata = r_th;
        ADDR_TL:       bus.rdata = r_tl;
        ADDR_TCON:     bus.rdata = {29'b0, r_tcon};
        ADDR_LED:      bus.rdata = 32'(r_led);
        ADDR_SWITCH:   bus.rdata = 32'(switch);
        ADDR_DIGI:     bus.rdata = {20'b0, r_digi};
        ADDR_UART_RXD: bus.rdata = w_rx_empty ? '0 : {24'b0, w_rx_head};
        ADDR_UART_CON: bus.rdata = w_ucon;
        default:       bus.rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_periph_bus_fifo.sv
// Bench for periph_bus_fifo with a 4-deep FIFO; UART TX line modelled as
// busy for 10 cycles after each start strobe.
module tb_periph_bus_fifo;
  import periph_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  led;
  logic [7:0]  switch = 8'h00;
  logic [11:0] digi;
  logic        irqout;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  int total = 0;
  int bad = 0;
  int tx_pulses = 0;
  int busy_cnt = 0;
  logic busy_model_en = 1'b1;
  logic force_busy = 1'b0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] tx_obs_q[$];
  logic [7:0] rx_model_q[$];

  periph_bus_fifo_if bus_if();

  periph_bus_fifo #(.FIFO_DEPTH(4), .LED_W(8), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .led(led), .switch(switch),
    .digi(digi), .irqout(irqout), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  initial forever #5 clk = ~clk;

  // UART line model: records each start strobe and its byte.
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1) busy_cnt = 0;
    else if (tx_start === 1'b1) begin
      tx_pulses++;
      tx_obs_q.push_back(tx_data);
      if (busy_model_en) busy_cnt = 10;
    end else if (busy_cnt > 0) busy_cnt--;
    tx_busy = force_busy | (busy_cnt > 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(posedge clk); #1;
    bus_if.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.rd = 1'b1; bus_if.addr = a;
    #1 d = bus_if.rdata;
    @(posedge clk); #1;
    bus_if.rd = 1'b0;
  endtask

  // Side-effect-free read between edges (never used on UART_RXD).
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus_if.rd = 1'b1; bus_if.addr = a;
    #1 d = bus_if.rdata;
    bus_if.rd = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic rx_model_push(input logic [7:0] d, inout logic ovf);
    if (rx_model_q.size() < 4) rx_model_q.push_back(d);
    else ovf = 1'b1;
    rx_pulse(d);
  endtask

  task automatic check_rx_drain(input string nm);
    logic [31:0] v;
    while (rx_model_q.size() > 0) begin
      logic [31:0] e;
      e = {24'b0, rx_model_q.pop_front()};
      bus_read(ADDR_UART_RXD, v);
      total++;
      if (v !== e) begin bad++; $display("FAIL %s: got %h expected %h", nm, v, e); end
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    total++; if (irqout !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b expected 0", irqout); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL rst_txstart: got %b expected 0", tx_start); end
    total++; if ({led, digi} !== 20'h0) begin bad++; $display("FAIL rst_leddigi: got %h expected 0", {led, digi}); end
    reset = 1'b1;
    @(negedge clk);
    peek(ADDR_TL, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_tl: got %h expected 0", v); end
    peek(ADDR_TCON, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rst_tcon: got %h expected 0", v); end
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h8) begin bad++; $display("FAIL rst_ucon: got %h expected 8", v); end
  endtask

  task automatic test_regs;
    logic [31:0] v;
    bus_write(ADDR_LED, 32'h1234_56A5);
    total++; if (led !== 8'hA5) begin bad++; $display("FAIL led_port: got %h expected a5", led); end
    peek(ADDR_LED, v);
    total++; if (v !== 32'hA5) begin bad++; $display("FAIL led_read: got %h expected a5", v); end
    bus_write(ADDR_DIGI, 32'hFFFF_FABC);
    total++; if (digi !== 12'hABC) begin bad++; $display("FAIL digi_port: got %h expected abc", digi); end
    peek(ADDR_DIGI, v);
    total++; if (v !== 32'hABC) begin bad++; $display("FAIL digi_read: got %h expected abc", v); end
    switch = 8'h3C;
    peek(ADDR_SWITCH, v);
    total++; if (v !== 32'h3C) begin bad++; $display("FAIL switch_read: got %h expected 3c", v); end
    bus_if.rd = 1'b0; bus_if.addr = ADDR_LED; #1;
    total++; if (bus_if.rdata !== 32'h0) begin bad++; $display("FAIL rd_low: got %h expected 0", bus_if.rdata); end
    peek(32'h4000_0024, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped: got %h expected 0", v); end
    peek(ADDR_UART_TXD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL txd_read: got %h expected 0", v); end
  endtask

  task automatic test_timer;
    logic [31:0] v;
    bus_write(ADDR_TH, 32'hFFFF_FFFE);
    bus_write(ADDR_TL, 32'hFFFF_FFFE);
    bus_write(ADDR_TCON, 32'h3);
    @(posedge clk); #1;
    peek(ADDR_TL, v);
    total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL tmr_inc: got %h expected ffffffff", v); end
    @(posedge clk); #1;
    peek(ADDR_TL, v);
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL tmr_reload: got %h expected fffffffe", v); end
    peek(ADDR_TCON, v);
    total++; if (v !== 32'h7) begin bad++; $display("FAIL tmr_tcon: got %h expected 7", v); end
    total++; if (irqout !== 1'b1) begin bad++; $display("FAIL tmr_irq: got %b expected 1", irqout); end
    bus_write(ADDR_TCON, 32'h0);
    total++; if (irqout !== 1'b0) begin bad++; $display("FAIL tmr_irq_clr: got %b expected 0", irqout); end
    bus_write(ADDR_TCON, 32'h1);
    bus_write(ADDR_TL, 32'h5);
    peek(ADDR_TL, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL tmr_wr_prio: got %h expected 5", v); end
    @(posedge clk); #1;
    peek(ADDR_TL, v);
    total++; if (v !== 32'h6) begin bad++; $display("FAIL tmr_after_wr: got %h expected 6", v); end
    bus_write(ADDR_TCON, 32'h0);
  endtask

  task automatic check_tx_scoreboard(input string nm, input int budget);
    int n;
    n = tx_exp_q.size();
    for (int i = 0; i < budget && tx_obs_q.size() < n; i++) @(negedge clk);
    total++;
    if (tx_obs_q.size() < n) begin
      bad++; $display("FAIL %s_timeout: got %0d bytes expected %0d", nm, tx_obs_q.size(), n);
    end
    while (tx_exp_q.size() > 0 && tx_obs_q.size() > 0) begin
      logic [7:0] e, o;
      e = tx_exp_q.pop_front(); o = tx_obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL %s_data: got %h expected %h", nm, o, e); end
    end
    tx_exp_q.delete();
  endtask

  task automatic test_tx;
    int p0;
    p0 = tx_pulses;
    bus_write(ADDR_UART_TXD, 32'h41); tx_exp_q.push_back(8'h41);
    bus_write(ADDR_UART_TXD, 32'h42); tx_exp_q.push_back(8'h42);
    check_tx_scoreboard("tx", 200);
    repeat (30) @(negedge clk);
    total++; if (tx_pulses !== p0 + 2) begin bad++; $display("FAIL tx_pulses: got %0d expected %0d", tx_pulses - p0, 2); end
  endtask

  task automatic test_tx_overflow;
    logic [31:0] v;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < 4) tx_exp_q.push_back(8'(8'h50 + i));
      bus_write(ADDR_UART_TXD, 32'h50 + i);
    end
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h22) begin bad++; $display("FAIL txovf_con: got %h expected 22", v); end
    bus_write(ADDR_UART_CON, 32'h20);
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h02) begin bad++; $display("FAIL txovf_w1c: got %h expected 02", v); end
    force_busy = 1'b0;
    check_tx_scoreboard("txovf", 400);
    repeat (20) @(negedge clk);
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h08) begin bad++; $display("FAIL txovf_drained: got %h expected 08", v); end
  endtask

  task automatic test_rx_overflow;
    logic [31:0] v;
    logic ovf;
    ovf = 1'b0;
    for (int unsigned i = 0; i < 5; i++) rx_model_push(8'(8'h10 + i), ovf);
    peek(ADDR_UART_CON, v);
    total++; if (v !== ({16'b0, 8'd4, 8'h0C} | {27'b0, ovf, 4'b0})) begin
      bad++; $display("FAIL rxovf_con: got %h expected %h", v, {16'b0, 8'd4, 8'h0C} | {27'b0, ovf, 4'b0});
    end
    check_rx_drain("rx_data");
    bus_read(ADDR_UART_RXD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rx_empty_read: got %h expected 0", v); end
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h18) begin bad++; $display("FAIL rxovf_sticky: got %h expected 18", v); end
    bus_write(ADDR_UART_CON, 32'h10);
  endtask

  task automatic test_rx_simul;
    logic [31:0] v, e;
    logic ovf;
    ovf = 1'b0;
    for (int unsigned i = 0; i < 4; i++) rx_model_push(8'(8'h30 + i), ovf);
    @(negedge clk);
    bus_if.rd = 1'b1; bus_if.addr = ADDR_UART_RXD;
    rx_valid = 1'b1; rx_data = 8'h34;
    #1 v = bus_if.rdata;
    e = {24'b0, rx_model_q.pop_front()};
    rx_model_q.push_back(8'h34);
    total++; if (v !== e) begin bad++; $display("FAIL simul_read: got %h expected %h", v, e); end
    @(posedge clk); #1;
    bus_if.rd = 1'b0; rx_valid = 1'b0;
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h40C) begin bad++; $display("FAIL simul_con: got %h expected 40c", v); end
    check_rx_drain("simul_drain");
  endtask

  task automatic test_ovf_vs_clear;
    logic [31:0] v;
    logic ovf;
    ovf = 1'b0;
    for (int unsigned i = 0; i < 4; i++) rx_model_push(8'(8'h60 + i), ovf);
    @(negedge clk);
    bus_if.wr = 1'b1; bus_if.addr = ADDR_UART_CON; bus_if.wdata = 32'h10;
    rx_valid = 1'b1; rx_data = 8'h64;
    @(posedge clk); #1;
    bus_if.wr = 1'b0; rx_valid = 1'b0;
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h41C) begin bad++; $display("FAIL ovf_beats_w1c: got %h expected 41c", v); end
    bus_write(ADDR_UART_CON, 32'h10);
    check_rx_drain("ovfclr_drain");
  endtask

  task automatic test_irq;
    logic [31:0] v;
`ifdef PERIPH_UART_IRQ_EN
    bus_write(ADDR_UART_CON, 32'h1);
    rx_pulse(8'h77);
    total++; if (irqout !== 1'b1) begin bad++; $display("FAIL irq_set: got %b expected 1", irqout); end
    bus_read(ADDR_UART_RXD, v);
    total++; if (v !== 32'h77) begin bad++; $display("FAIL irq_read: got %h expected 77", v); end
    total++; if (irqout !== 1'b0) begin bad++; $display("FAIL irq_clr: got %b expected 0", irqout); end
    bus_write(ADDR_UART_CON, 32'h0);
`else
    bus_write(ADDR_UART_CON, 32'h1);
    peek(ADDR_UART_CON, v);
    total++; if (v !== 32'h08) begin bad++; $display("FAIL irqen_ro: got %h expected 08", v); end
    rx_pulse(8'h77);
    total++; if (irqout !== 1'b0) begin bad++; $display("FAIL irq_off: got %b expected 0", irqout); end
    bus_read(ADDR_UART_RXD, v);
    total++; if (v !== 32'h77) begin bad++; $display("FAIL irq_read: got %h expected 77", v); end
`endif
  endtask

  task automatic test_reset_mid_tx;
    logic [31:0] v;
    int p0;
    p0 = tx_pulses;
    busy_model_en = 1'b0;
    tx_obs_q.delete();
    for (int unsigned i = 1; i <= 3; i++) bus_write(ADDR_UART_TXD, i);
    for (int i = 0; i < 50 && tx_pulses == p0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++; if (dut.r_tx_state !== TX_WAIT_BUSY) begin bad++; $display("FAIL mid_wait: got %0d expected %0d", dut.r_tx_state, TX_WAIT_BUSY); end
    total++; if (tx_obs_q.size() != 1 || tx_obs_q[0] !== 8'h01) begin
      bad++; $display("FAIL mid_first: got %0d bytes expected one byte 01", tx_obs_q.size());
    end
    reset = 1'b0;
    #1;
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_txstart: got %b expected 0", tx_start); end
    total++; if (dut.r_tx_state !== TX_IDLE) begin bad++; $display("FAIL mid_idle: got %0d expected %0d", dut.r_tx_state, TX_IDLE); end
    peek(ADDR_UART_CON, v);
    total++; if (v[UCON_TX_EMPTY] !== 1'b1) begin bad++; $display("FAIL mid_txempty: got %b expected 1", v[UCON_TX_EMPTY]); end
    total++; if (irqout !== 1'b0) begin bad++; $display("FAIL mid_irq: got %b expected 0", irqout); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    busy_model_en = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (tx_pulses !== p0 + 1) begin bad++; $display("FAIL mid_no_pulse: got %0d expected %0d", tx_pulses - p0, 1); end
  endtask

  initial begin
    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    test_reset();
    test_regs();
    test_timer();
    test_tx();
    test_tx_overflow();
    test_rx_overflow();
    test_rx_simul();
    test_ovf_vs_clear();
    test_irq();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
